// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: DMType access sizes,
// arbiter FSM states, round-robin owner and the debug abort pattern.
package dmem_arbiter_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    DBG_ACC  = 2'd2,
    CPU_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DBG = 1'b1
  } grant_e;

  localparam logic [31:0] DBG_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_arbiter_dm_lane.sv
// Sub-word lane handling: byte enables, store-lane replication, load lane
// extraction with sign/zero extension, and misalignment detection.
module dm_lane
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]  addr_low,
  input  logic [2:0]  dmtype,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_word[{addr_low, 3'b000} +: 8];
  assign half_sel = addr_low[1] ? rdata_word[31:16] : rdata_word[15:0];

  // Unknown encodings fall through to word behaviour.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata_word;
    misaligned = 1'b0;
    case (dmtype)
      dm_byte, dm_byte_unsigned: begin
        be         = 4'b0001 << addr_low;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (dmtype == dm_byte) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h0, byte_sel};
      end
      dm_halfword, dm_halfword_unsigned: begin
        be         = 4'b0011 << {addr_low[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (dmtype == dm_halfword) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0, half_sel};
        misaligned = addr_low[0];
      end
      default: begin
        misaligned = |addr_low;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and a
// debug/loader port, stalling the CPU until its access retires.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  arb_state_e    state, state_next;
  grant_e        last_grant;
  logic [CW-1:0] timer;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        misaligned;
  logic        dbg_pending;
  logic        timeout_hit;
  logic        grant_cpu;
  logic        grant_dbg;
  logic        cpu_reject;

  dm_lane u_lane (
    .addr_low   (cpu_addr[1:0]),
    .dmtype     (cpu_dmtype),
    .wdata      (cpu_wdata),
    .rdata_word (mem_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misaligned (misaligned)
  );

  // A debug request still high during its own ack pulse is already served.
  assign dbg_pending = dbg_req & ~dbg_ack;
  assign timeout_hit = (timer == CW'(TIMEOUT - 1));
  assign cpu_stall   = cpu_req & (state != CPU_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_cpu  = 1'b0;
    grant_dbg  = 1'b0;
    cpu_reject = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && misaligned) begin
          cpu_reject = 1'b1;
          state_next = CPU_DONE;
        end else if (cpu_req && (!dbg_pending || last_grant == GRANT_DBG)) begin
          grant_cpu  = 1'b1;
          state_next = CPU_ACC;
        end else if (dbg_pending) begin
          grant_dbg  = 1'b1;
          state_next = DBG_ACC;
        end
      end
      CPU_ACC:  if (mem_ack || timeout_hit) state_next = CPU_DONE;
      DBG_ACC:  if (mem_ack || timeout_hit) state_next = IDLE;
      CPU_DONE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: latch the granted request, capture the response or abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
      cpu_rdata  <= 32'h0;
      cpu_err    <= 1'b0;
      dbg_rdata  <= 32'h0;
      dbg_ack    <= 1'b0;
      timer      <= '0;
      last_grant <= GRANT_DBG;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (cpu_reject) begin
            cpu_err   <= 1'b1;
            cpu_rdata <= 32'h0;
          end else if (grant_cpu) begin
            mem_req    <= 1'b1;
            mem_we     <= cpu_we;
            mem_addr   <= {cpu_addr[31:2], 2'b00};
            mem_be     <= cpu_we ? lane_be : 4'b1111;
            mem_wdata  <= lane_wdata;
            last_grant <= GRANT_CPU;
          end else if (grant_dbg) begin
            mem_req    <= 1'b1;
            mem_we     <= dbg_we;
            mem_addr   <= dbg_addr & 32'hFFFF_FFFC;
            mem_be     <= 4'b1111;
            mem_wdata  <= dbg_wdata;
            last_grant <= GRANT_DBG;
          end
        end
        CPU_ACC, DBG_ACC: begin
          timer <= timer + 1'b1;
          if (mem_ack || timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
          if (state == CPU_ACC) begin
            if (mem_ack) begin
              cpu_rdata <= lane_rdata;
            end else if (timeout_hit) begin
              cpu_rdata <= 32'h0;
              cpu_err   <= 1'b1;
            end
          end else begin
            if (mem_ack) begin
              dbg_rdata <= mem_rdata;
              dbg_ack   <= 1'b1;
            end else if (timeout_hit) begin
              dbg_rdata <= DBG_ABORT_DATA;
              dbg_ack   <= 1'b1;
            end
          end
        end
        CPU_DONE: cpu_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
